// File: rtl/cg_hyst_ctrl.sv
// cg_hyst_ctrl: N-channel clock-gate controller with idle hysteresis and per-channel Q polarity.
// Define CG_STATS_EN to add per-channel saturating gated-cycle counters (STAT_CNT readout).
module cg_hyst_ctrl #(
  parameter int unsigned      N_CH     = 4,
  parameter int unsigned      HOLD_CYC = 8,
  parameter logic [N_CH-1:0]  POL_MASK = '0,
  parameter int unsigned      CNT_W    = 16,
  localparam int unsigned     SEL_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              CP,
  input  logic              CD,
  input  logic [N_CH-1:0]   E,
  input  logic              TE,
  output logic [N_CH-1:0]   Q,
  output logic [N_CH-1:0]   GATED,
  input  logic [SEL_W-1:0]  STAT_SEL,
  input  logic              STAT_CLR,
  output logic [CNT_W-1:0]  STAT_CNT
);

  localparam int unsigned HOLD_W = 8;
  localparam logic [HOLD_W-1:0] HOLD_INIT =
    (HOLD_CYC == 0) ? HOLD_W'(0) : HOLD_W'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_GATED = 2'd2
  } state_e;

  state_e            state_q [N_CH];
  state_e            state_d [N_CH];
  logic [HOLD_W-1:0] cnt_q   [N_CH];
  logic [HOLD_W-1:0] cnt_d   [N_CH];
  logic [N_CH-1:0]   gated_q;
  logic [N_CH-1:0]   gated_d;
  logic [N_CH-1:0]   en_int_c;
  logic [N_CH-1:0]   en_l;

  always_ff @(posedge CP) begin
    if (CD) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= ST_RUN;
        cnt_q[i]   <= '0;
      end
      gated_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      gated_q <= gated_d;
    end
  end

  // Per-channel RUN/HOLD/GATED next state; wake is immediate, gating waits HOLD_CYC idle cycles
  always_comb begin
    gated_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        ST_RUN: begin
          if (!E[i]) begin
            if (HOLD_CYC == 0) begin
              state_d[i] = ST_GATED;
            end else begin
              state_d[i] = ST_HOLD;
              cnt_d[i]   = HOLD_INIT;
            end
          end
        end
        ST_HOLD: begin
          if (E[i]) begin
            state_d[i] = ST_RUN;
          end else if (cnt_q[i] == '0) begin
            state_d[i] = ST_GATED;
          end else begin
            cnt_d[i] = cnt_q[i] - HOLD_W'(1);
          end
        end
        ST_GATED: begin
          if (E[i]) begin
            state_d[i] = ST_RUN;
          end
        end
        default: state_d[i] = ST_RUN;
      endcase
      gated_d[i] = (state_d[i] == ST_GATED);
    end
  end

  always_comb begin
    en_int_c = '0;
    for (int i = 0; i < N_CH; i++) begin
      en_int_c[i] = E[i] | TE | (state_q[i] != ST_GATED);
    end
  end

  // Enable latch: transparent in the low phase so E/TE set up before the edge wake with zero latency
  always_latch begin
    if (!CP) begin
      en_l <= en_int_c;
    end
  end

  always_comb begin
    Q = '0;
    for (int i = 0; i < N_CH; i++) begin
      Q[i] = POL_MASK[i] ? (~en_l[i] | CP) : (en_l[i] & CP);
    end
  end

  assign GATED = gated_q;

`ifdef CG_STATS_EN
  logic [CNT_W-1:0] stat_q [N_CH];
  logic [CNT_W-1:0] stat_d [N_CH];

  always_ff @(posedge CP) begin
    if (CD) begin
      for (int i = 0; i < N_CH; i++) begin
        stat_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        stat_q[i] <= stat_d[i];
      end
    end
  end

  // Clear has priority over counting; counters stick at all-ones
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      stat_d[i] = stat_q[i];
      if (STAT_CLR) begin
        stat_d[i] = '0;
      end else if ((state_q[i] == ST_GATED) && !en_int_c[i] && (stat_q[i] != '1)) begin
        stat_d[i] = stat_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    STAT_CNT = '0;
    if (32'(STAT_SEL) < N_CH) begin
      STAT_CNT = stat_q[STAT_SEL];
    end
  end
`else
  logic unused_stat_c;
  assign unused_stat_c = ^{STAT_SEL, STAT_CLR};
  assign STAT_CNT      = '0;
`endif

endmodule

// File: tb/tb_cg_hyst_ctrl.sv
// Bench for cg_hyst_ctrl: directed scenarios plus randomized traffic against an idle-run-length model.
// Two instances: HOLD_CYC=8 with channel 1 high-idle, and HOLD_CYC=0.
module tb_cg_hyst_ctrl;

  localparam int unsigned HOLD_M = 8;
  localparam int unsigned HOLD_Z = 0;
  localparam logic [3:0]  POL_M  = 4'b0010;
  localparam logic [3:0]  POL_Z  = 4'b0000;

  logic       CP = 1'b0;
  logic       CD = 1'b1;
  logic       TE = 1'b0;
  logic       STAT_CLR = 1'b0;
  logic [3:0] E = 4'hF;
  logic [1:0] STAT_SEL = 2'd0;
  logic [3:0] q_m, gated_m, stat_m;
  logic [3:0] q_z, gated_z, stat_z;

  int n_tests = 0;
  int n_fail  = 0;

  // model: consecutive cycles each channel has seen E=0 since reset or last E=1
  int         idle_m [4];
  int         idle_z [4];
  logic [3:0] sm_m   [4];
  logic [3:0] sm_z   [4];
  logic [3:0] en_m, en_z;

  always #5 CP = ~CP;

  cg_hyst_ctrl #(.N_CH(4), .HOLD_CYC(HOLD_M), .POL_MASK(POL_M), .CNT_W(4)) dut_m (
    .CP(CP), .CD(CD), .E(E), .TE(TE), .Q(q_m), .GATED(gated_m),
    .STAT_SEL(STAT_SEL), .STAT_CLR(STAT_CLR), .STAT_CNT(stat_m)
  );

  cg_hyst_ctrl #(.N_CH(4), .HOLD_CYC(HOLD_Z), .POL_MASK(POL_Z), .CNT_W(4)) dut_z (
    .CP(CP), .CD(CD), .E(E), .TE(TE), .Q(q_z), .GATED(gated_z),
    .STAT_SEL(STAT_SEL), .STAT_CLR(STAT_CLR), .STAT_CNT(stat_z)
  );

  function automatic logic gm(input int i);
    return idle_m[i] > int'(HOLD_M);
  endfunction

  function automatic logic gz(input int i);
    return idle_z[i] > int'(HOLD_Z);
  endfunction

  function automatic logic [3:0] stat_exp(input logic [3:0] v);
`ifdef CG_STATS_EN
    return v;
`else
    return (v & 4'h0);
`endif
  endfunction

  // drive in the low phase and record the enable each channel's latch should capture
  task automatic drive(input logic [3:0] e, input logic te, input logic cd,
                       input logic clr, input logic [1:0] sel);
    if (CP) @(negedge CP);
    #1;
    E = e; TE = te; CD = cd; STAT_CLR = clr; STAT_SEL = sel;
    for (int i = 0; i < 4; i++) begin
      en_m[i] = e[i] | te | !gm(i);
      en_z[i] = e[i] | te | !gz(i);
    end
  endtask

  // step past the rising edge and update the model
  task automatic advance();
    @(posedge CP);
    #2;
    for (int i = 0; i < 4; i++) begin
      if (CD || STAT_CLR) sm_m[i] = 4'h0;
      else if (gm(i) && !en_m[i] && sm_m[i] != 4'hF) sm_m[i] = sm_m[i] + 4'h1;
      if (CD || STAT_CLR) sm_z[i] = 4'h0;
      else if (gz(i) && !en_z[i] && sm_z[i] != 4'hF) sm_z[i] = sm_z[i] + 4'h1;
      if (CD || E[i]) begin
        idle_m[i] = 0;
        idle_z[i] = 0;
      end else begin
        if (idle_m[i] < 1000) idle_m[i] = idle_m[i] + 1;
        if (idle_z[i] < 1000) idle_z[i] = idle_z[i] + 1;
      end
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive(4'($urandom_range(0, 15)), 1'b0, 1'b1, 1'b0, 2'd0);
      advance();
      n_tests++;
      if (gated_m !== 4'h0 || gated_z !== 4'h0) begin
        n_fail++;
        $display("FAIL reset_gated: got m=%b z=%b, want 0000", gated_m, gated_z);
      end
      n_tests++;
      if (q_m !== 4'hF || q_z !== 4'hF) begin
        n_fail++;
        $display("FAIL reset_q_high: got m=%b z=%b, want 1111", q_m, q_z);
      end
      n_tests++;
      if (stat_m !== 4'h0) begin
        n_fail++;
        $display("FAIL reset_stat: got %0d, want 0", stat_m);
      end
    end
  endtask

  // T1: gating delay after reset release with E=0
  task automatic test_gate_latency();
    int pulses = 0;
    int rise_edge = -1;
    for (int k = 1; k <= 14; k++) begin
      drive(4'h0, 1'b0, 1'b0, 1'b0, 2'd0);
      n_tests++;
      if (q_m[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL t1_low_phase k=%0d: got q0=%b, want 0", k, q_m[0]);
      end
      advance();
      if (q_m[0] === 1'b1) pulses++;
      if (gated_m[0] === 1'b1 && rise_edge < 0) rise_edge = k;
      n_tests++;
      if (gated_m[0] !== gm(0)) begin
        n_fail++;
        $display("FAIL t1_gated k=%0d: got %b, want %b", k, gated_m[0], gm(0));
      end
    end
    n_tests++;
    if (pulses != int'(HOLD_M) + 1) begin
      n_fail++;
      $display("FAIL t1_pulse_count: got %0d, want %0d", pulses, HOLD_M + 1);
    end
    n_tests++;
    if (rise_edge != int'(HOLD_M) + 1) begin
      n_fail++;
      $display("FAIL t1_gated_edge: got %0d, want %0d", rise_edge, HOLD_M + 1);
    end
  endtask

  // T2: zero-latency wake from GATED
  task automatic test_wake();
    drive(4'b0001, 1'b0, 1'b0, 1'b0, 2'd0);
    advance();
    n_tests++;
    if (q_m[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL t2_wake_pulse: got q0=%b, want 1", q_m[0]);
    end
    n_tests++;
    if (gated_m[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL t2_wake_gated: got %b, want 0", gated_m[0]);
    end
  endtask

  // T3: one-cycle E pulse during HOLD restarts the full window
  task automatic test_hold_restart();
    int rise_edge = -1;
    logic e1;
    drive(4'hF, 1'b0, 1'b0, 1'b0, 2'd0);
    advance();
    for (int k = 1; k <= 20; k++) begin
      e1 = (k == 6);
      drive({2'b00, e1, 1'b0}, 1'b0, 1'b0, 1'b0, 2'd0);
      advance();
      if (gated_m[1] === 1'b1 && rise_edge < 0) rise_edge = k;
      n_tests++;
      if (gated_m[1] !== gm(1)) begin
        n_fail++;
        $display("FAIL t3_gated k=%0d: got %b, want %b", k, gated_m[1], gm(1));
      end
    end
    n_tests++;
    if (rise_edge != 6 + int'(HOLD_M) + 1) begin
      n_fail++;
      $display("FAIL t3_gated_edge: got %0d, want %0d", rise_edge, 6 + HOLD_M + 1);
    end
  endtask

  // T4: high-idle channel 1 stays high while gated; TE passes CP through
  task automatic test_polarity_te();
    for (int k = 0; k < 3; k++) begin
      drive(4'h0, 1'b0, 1'b0, 1'b0, 2'd0);
      n_tests++;
      if (q_m[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL t4_idle_high_lo k=%0d: got %b, want 1", k, q_m[1]);
      end
      advance();
      n_tests++;
      if (q_m[1] !== 1'b1 || gated_m[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL t4_idle_high_hi k=%0d: got q1=%b g1=%b, want 1 1", k, q_m[1], gated_m[1]);
      end
    end
    for (int k = 0; k < 3; k++) begin
      drive(4'h0, 1'b1, 1'b0, 1'b0, 2'd0);
      #1;
      n_tests++;
      if (q_m[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL t4_te_low k=%0d: got %b, want 0", k, q_m[1]);
      end
      advance();
      n_tests++;
      if (gated_m[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL t4_te_gated k=%0d: got %b, want 1", k, gated_m[1]);
      end
      n_tests++;
      if (q_m[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL t4_te_q0 k=%0d: got %b, want 1", k, q_m[0]);
      end
    end
  endtask

  // T5: HOLD_CYC=0 gates at the first idle edge
  task automatic test_hold0();
    drive(4'hF, 1'b0, 1'b0, 1'b0, 2'd0);
    advance();
    drive(4'b1110, 1'b0, 1'b0, 1'b0, 2'd0);
    advance();
    n_tests++;
    if (q_z[0] !== 1'b1 || gated_z[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL t5_edge_k: got q0=%b g0=%b, want 1 1", q_z[0], gated_z[0]);
    end
    drive(4'b1110, 1'b0, 1'b0, 1'b0, 2'd0);
    advance();
    n_tests++;
    if (q_z[0] !== 1'b0 || gated_z[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL t5_edge_k1: got q0=%b g0=%b, want 0 1", q_z[0], gated_z[0]);
    end
  endtask

  // T6: gated-cycle counter saturation and clear
  task automatic test_stats();
    drive(4'hF, 1'b0, 1'b0, 1'b0, 2'd2);
    advance();
    for (int k = 0; k < int'(HOLD_M) + 1 + 20; k++) begin
      drive(4'h0, 1'b0, 1'b0, 1'b0, 2'd2);
      advance();
    end
    n_tests++;
    if (stat_m !== stat_exp(4'hF)) begin
      n_fail++;
      $display("FAIL t6_saturate: got %0d, want %0d", stat_m, stat_exp(4'hF));
    end
    drive(4'h0, 1'b0, 1'b0, 1'b1, 2'd2);
    advance();
    n_tests++;
    if (stat_m !== 4'h0) begin
      n_fail++;
      $display("FAIL t6_clear: got %0d, want 0", stat_m);
    end
    drive(4'h0, 1'b0, 1'b0, 1'b0, 2'd2);
    advance();
    n_tests++;
    if (stat_m !== stat_exp(4'h1)) begin
      n_fail++;
      $display("FAIL t6_after_clear: got %0d, want %0d", stat_m, stat_exp(4'h1));
    end
  endtask

  task automatic test_random();
    logic [3:0] e, exp_lo_m, exp_hi_m, exp_lo_z, exp_hi_z, eg_m, eg_z;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) e[i] = ($urandom_range(0, 9) < 2);
      drive(e, ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0),
            ($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)));
      for (int i = 0; i < 4; i++) begin
        exp_lo_m[i] = POL_M[i] ? ~en_m[i] : 1'b0;
        exp_hi_m[i] = POL_M[i] ? 1'b1 : en_m[i];
        exp_lo_z[i] = POL_Z[i] ? ~en_z[i] : 1'b0;
        exp_hi_z[i] = POL_Z[i] ? 1'b1 : en_z[i];
      end
      #1;
      n_tests++;
      if (q_m !== exp_lo_m || q_z !== exp_lo_z) begin
        n_fail++;
        $display("FAIL rnd_q_low c=%0d: got m=%b z=%b, want m=%b z=%b", c, q_m, q_z, exp_lo_m, exp_lo_z);
      end
      advance();
      for (int i = 0; i < 4; i++) begin
        eg_m[i] = gm(i);
        eg_z[i] = gz(i);
      end
      n_tests++;
      if (q_m !== exp_hi_m || q_z !== exp_hi_z) begin
        n_fail++;
        $display("FAIL rnd_q_high c=%0d: got m=%b z=%b, want m=%b z=%b", c, q_m, q_z, exp_hi_m, exp_hi_z);
      end
      n_tests++;
      if (gated_m !== eg_m || gated_z !== eg_z) begin
        n_fail++;
        $display("FAIL rnd_gated c=%0d: got m=%b z=%b, want m=%b z=%b", c, gated_m, gated_z, eg_m, eg_z);
      end
      n_tests++;
      if (stat_m !== stat_exp(sm_m[STAT_SEL]) || stat_z !== stat_exp(sm_z[STAT_SEL])) begin
        n_fail++;
        $display("FAIL rnd_stat c=%0d sel=%0d: got m=%0d z=%0d, want m=%0d z=%0d", c, STAT_SEL,
                 stat_m, stat_z, stat_exp(sm_m[STAT_SEL]), stat_exp(sm_z[STAT_SEL]));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      idle_m[i] = 0;
      idle_z[i] = 0;
      sm_m[i]   = 4'h0;
      sm_z[i]   = 4'h0;
    end
    en_m = 4'hF;
    en_z = 4'hF;
    test_reset();
    test_gate_latency();
    test_wake();
    test_hold_restart();
    test_polarity_te();
    test_hold0();
    test_stats();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
